// File: rtl/reg_writeback_pkg.sv
// Shared encodings for the register writeback stage: load sizes and
// architecturally fixed register numbers.
package reg_writeback_pkg;

  typedef enum logic [1:0] {
    LOAD_WORD = 2'b00,
    LOAD_HALF = 2'b01,
    LOAD_BYTE = 2'b10,
    LOAD_RSVD = 2'b11
  } loadSize_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_LINK = 5'd31;

endpackage

// File: rtl/reg_writeback_load_align.sv
// Big-endian load lane selection and zero/sign extension.
// Misaligned halves fall back to offset[1]; misaligned words pass unchanged.
module load_align
  import reg_writeback_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  loadSize_e   size,
  input  logic        loadSigned,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    case (offset)
      2'd0:    byteSel = word[31:24];
      2'd1:    byteSel = word[23:16];
      2'd2:    byteSel = word[15:8];
      default: byteSel = word[7:0];
    endcase
    halfSel = offset[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    data       = word;
    misaligned = 1'b0;
    case (size)
      LOAD_BYTE: data = {{24{loadSigned & byteSel[7]}}, byteSel};
      LOAD_HALF: begin
        data       = {{16{loadSigned & halfSel[15]}}, halfSel};
        misaligned = offset[0];
      end
      default:   misaligned = (offset != 2'd0);
    endcase
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: resolves destination/data for each accepted result and
// buffers register-file writes in a small FIFO drained around wb_stall.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_alu_result,
  input  logic [31:0]                in_mem_data,
  input  logic                       in_reg_write,
  input  logic                       in_reg_dst,
  input  logic                       in_mem_to_reg,
  input  logic                       in_link,
  input  logic                       in_load_signed,
  input  logic [1:0]                 in_load_size,
  input  logic                       wb_stall,
  output logic                       wb_en,
  output logic [4:0]                 wb_addr,
  output logic [31:0]                wb_data,
  output logic                       misalign_err,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  logic [PtrW-1:0] rdPtr, wrPtr;
  logic [CntW-1:0] count;
  logic [4:0]      addrMem [DEPTH];
  logic [31:0]     dataMem [DEPTH];

  logic [4:0]  destAddr;
  logic [31:0] alignedData, writeData;
  logic        loadMisaligned;
  logic        accept, enqueue, retire;
  logic        unusedInstrBits;

  assign unusedInstrBits = ^{in_instr[31:21], in_instr[10:0]};

  load_align uAlign (
    .word       (in_mem_data),
    .offset     (in_alu_result[1:0]),
    .size       (loadSize_e'(in_load_size)),
    .loadSigned (in_load_signed),
    .data       (alignedData),
    .misaligned (loadMisaligned)
  );

  always_comb begin
    if (in_link)         destAddr = REG_LINK;
    else if (in_reg_dst) destAddr = in_instr[15:11];
    else                 destAddr = in_instr[20:16];
  end

  assign writeData = (in_link || !in_mem_to_reg) ? in_alu_result : alignedData;

  // Readiness deliberately ignores retire so a full buffer never chains
  // through wb_stall into the upstream handshake.
  assign in_ready = rst_n && (count < CntW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign enqueue  = accept && in_reg_write && (destAddr != REG_ZERO);
  assign retire   = wb_en;

  assign wb_en   = (count != '0) && !wb_stall;
  assign wb_addr = (count != '0) ? addrMem[rdPtr] : 5'd0;
  assign wb_data = (count != '0) ? dataMem[rdPtr] : 32'd0;
  assign pending = count;

  always_ff @(posedge clk) begin
    if (enqueue) begin
      addrMem[wrPtr] <= destAddr;
      dataMem[wrPtr] <= writeData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr        <= '0;
      wrPtr        <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (enqueue) wrPtr <= wrPtr + 1'b1;
      if (retire)  rdPtr <= rdPtr + 1'b1;
      case ({enqueue, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      misalign_err <= accept && in_mem_to_reg && !in_link && loadMisaligned;
    end
  end

endmodule
